// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Two-port round-robin arbiter for a single 16-bit-address,
//               8-bit-data memory bus. A three-state FSM (IDLE/ACCESS/DONE)
//               owns the bus for WAIT_STATES+1 access cycles, then pulses
//               the winner's ack for one cycle. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    // Extra memory cycles per access; the access counter is 4 bits wide,
    // so legal values are 0..15.
    parameter int WAIT_STATES = 1
) (
    input  logic        clk_in,
    input  logic        reset,

    // Port 0: CPU control unit
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [15:0] p0_addr,
    input  logic [7:0]  p0_wdata,
    output logic        p0_gnt,
    output logic        p0_ack,
    output logic [7:0]  p0_rdata,

    // Port 1: debug step / DMA
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [15:0] p1_addr,
    input  logic [7:0]  p1_wdata,
    output logic        p1_gnt,
    output logic        p1_ack,
    output logic [7:0]  p1_rdata,

    // Memory side
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,

    output logic        busy
);

    localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_q;
    logic        last_q;      // port served most recently (1 = port 1)
    logic        owner_q;     // port owning the access in flight
    logic        we_q;        // latched write enable of the access in flight
    logic [3:0]  cnt_q;       // remaining ACCESS cycles after the current one

    logic        p0_gnt_q,  p1_gnt_q;
    logic        p0_ack_q,  p1_ack_q;
    logic [7:0]  p0_rdata_q, p1_rdata_q;
    logic        mem_en_q,  mem_we_q;
    logic [15:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;
    logic        busy_q;

    // Arbitration result and the winner's request fields.
    logic        any_req_d;
    logic        win_d;
    logic        sel_we_d;
    logic [15:0] sel_addr_d;
    logic [7:0]  sel_wdata_d;

    // Pick the winner: a lone requester wins; on a tie the port not served
    // last wins, so a held request can never be starved.
    always_comb begin
        any_req_d   = p0_req | p1_req;
        win_d       = (p0_req & p1_req) ? ~last_q : ~p0_req;
        sel_we_d    = win_d ? p1_we    : p0_we;
        sel_addr_d  = win_d ? p1_addr  : p0_addr;
        sel_wdata_d = win_d ? p1_wdata : p0_wdata;
    end

    // Bus FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= 4'd0;
            p0_gnt_q    <= 1'b0;
            p1_gnt_q    <= 1'b0;
            p0_ack_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
            p0_rdata_q  <= 8'h00;
            p1_rdata_q  <= 8'h00;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    p0_ack_q <= 1'b0;
                    p1_ack_q <= 1'b0;
                    if (any_req_d) begin
                        // Latch the winner's request; the memory-side
                        // registers double as the latched address/data.
                        state_q     <= ST_ACCESS;
                        last_q      <= win_d;
                        owner_q     <= win_d;
                        we_q        <= sel_we_d;
                        cnt_q       <= C_WAIT_LOAD;
                        p0_gnt_q    <= ~win_d;
                        p1_gnt_q    <= win_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= sel_we_d;
                        mem_addr_q  <= sel_addr_d;
                        mem_wdata_q <= sel_wdata_d;
                        busy_q      <= 1'b1;
                    end
                end

                ST_ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        // Last access cycle: mem_rdata is valid now.
                        if (!we_q) begin
                            if (owner_q) begin
                                p1_rdata_q <= mem_rdata;
                            end else begin
                                p0_rdata_q <= mem_rdata;
                            end
                        end
                        state_q  <= ST_DONE;
                        p0_gnt_q <= 1'b0;
                        p1_gnt_q <= 1'b0;
                        p0_ack_q <= ~owner_q;
                        p1_ack_q <= owner_q;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                ST_DONE: begin
                    // Ack lasts exactly one cycle; requests are not looked
                    // at here, only in the following IDLE cycle.
                    state_q  <= ST_IDLE;
                    p0_ack_q <= 1'b0;
                    p1_ack_q <= 1'b0;
                    busy_q   <= 1'b0;
                end

                default: begin
                    state_q  <= ST_IDLE;
                    p0_gnt_q <= 1'b0;
                    p1_gnt_q <= 1'b0;
                    p0_ack_q <= 1'b0;
                    p1_ack_q <= 1'b0;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign p0_gnt    = p0_gnt_q;
    assign p1_gnt    = p1_gnt_q;
    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed self-checking bench for mem_bus_arbiter. Three
//               instances (WAIT_STATES = 0, 1, 3) share one stimulus set;
//               each scenario checks the instance it targets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [15:0] p0_addr, p1_addr;
    logic [7:0]  p0_wdata, p1_wdata, mem_rdata;

    logic [2:0]  p0_gnt, p1_gnt, p0_ack, p1_ack, mem_en, mem_we, busy;
    logic [7:0]  p0_rdata  [3];
    logic [7:0]  p1_rdata  [3];
    logic [15:0] mem_addr  [3];
    logic [7:0]  mem_wdata [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instance 0: WAIT_STATES=0, instance 1: 1, instance 2: 3.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        mem_bus_arbiter #(.WAIT_STATES(WS)) u_dut (
            .clk_in    (clk),
            .reset     (reset),
            .p0_req    (p0_req),
            .p0_we     (p0_we),
            .p0_addr   (p0_addr),
            .p0_wdata  (p0_wdata),
            .p0_gnt    (p0_gnt[g]),
            .p0_ack    (p0_ack[g]),
            .p0_rdata  (p0_rdata[g]),
            .p1_req    (p1_req),
            .p1_we     (p1_we),
            .p1_addr   (p1_addr),
            .p1_wdata  (p1_wdata),
            .p1_gnt    (p1_gnt[g]),
            .p1_ack    (p1_ack[g]),
            .p1_rdata  (p1_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata),
            .busy      (busy[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Status word: {p0_gnt, p1_gnt, p0_ack, p1_ack, mem_en, mem_we, busy}
    function automatic logic [31:0] st(input int i);
        return {25'd0, p0_gnt[i], p1_gnt[i], p0_ack[i], p1_ack[i], mem_en[i], mem_we[i], busy[i]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 16'h0; p0_wdata = 8'h0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 16'h0; p1_wdata = 8'h0;
        mem_rdata = 8'h00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Status patterns
    localparam logic [31:0] S_IDLE  = 32'b0000000;
    localparam logic [31:0] S_ACC0  = 32'b1000101;
    localparam logic [31:0] S_ACC1  = 32'b0100101;
    localparam logic [31:0] S_WR1   = 32'b0100111;
    localparam logic [31:0] S_DONE0 = 32'b0010001;
    localparam logic [31:0] S_DONE1 = 32'b0001001;

    logic [31:0] rr_exp [8];

    initial begin
        rr_exp[0] = S_IDLE;  rr_exp[1] = S_ACC0; rr_exp[2] = S_ACC0; rr_exp[3] = S_DONE0;
        rr_exp[4] = S_IDLE;  rr_exp[5] = S_ACC1; rr_exp[6] = S_ACC1; rr_exp[7] = S_DONE1;

        // ---------------- reset values ----------------
        do_reset();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst_status[%0d]", i), st(i), S_IDLE);
            check_eq($sformatf("rst_addr[%0d]", i), {16'd0, mem_addr[i]}, 32'h0);
            check_eq($sformatf("rst_rdata[%0d]", i), {16'd0, p0_rdata[i], p1_rdata[i]}, 32'h0);
        end

        // ---------------- WS=1: p0 read of 0x0001 ----------------
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0001; mem_rdata = 8'hFF;
        tick();
        check_eq("rd_ws1_n1", st(1), S_ACC0);
        check_eq("rd_ws1_addr", {16'd0, mem_addr[1]}, 32'h0001);
        tick();
        check_eq("rd_ws1_n2", st(1), S_ACC0);
        tick();
        check_eq("rd_ws1_n3_ack", st(1), S_DONE0);
        check_eq("rd_ws1_rdata", {24'd0, p0_rdata[1]}, 32'hFF);
        p0_req = 1'b0;
        tick();
        check_eq("rd_ws1_idle", st(1), S_IDLE);

        // ---------------- WS=0: p1 write 0x5A to 0x0010 ----------------
        do_reset();
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h0010; p1_wdata = 8'h5A; mem_rdata = 8'h33;
        tick();
        check_eq("wr_ws0_n1", st(0), S_WR1);
        check_eq("wr_ws0_addr", {16'd0, mem_addr[0]}, 32'h0010);
        check_eq("wr_ws0_wdata", {24'd0, mem_wdata[0]}, 32'h5A);
        tick();
        check_eq("wr_ws0_n2_ack", st(0), S_DONE1);
        check_eq("wr_ws0_rdata", {24'd0, p1_rdata[0]}, 32'h00);
        p1_req = 1'b0; p1_we = 1'b0;
        tick();
        check_eq("wr_ws0_idle", st(0), S_IDLE);

        // ---------------- WS=1: simultaneous reads, p0 first ----------------
        do_reset();
        p0_req = 1'b1; p0_addr = 16'h0020;
        p1_req = 1'b1; p1_addr = 16'h0030;
        mem_rdata = 8'h11;
        for (int c = 1; c <= 7; c++) begin
            tick();
            check_eq($sformatf("tie_c%0d", c), st(1), rr_exp[c]);
            if (c == 1) check_eq("tie_addr0", {16'd0, mem_addr[1]}, 32'h0020);
            if (c == 5) check_eq("tie_addr1", {16'd0, mem_addr[1]}, 32'h0030);
            if (c == 3) begin
                check_eq("tie_p0_rdata", {24'd0, p0_rdata[1]}, 32'h11);
                p0_req = 1'b0;
                mem_rdata = 8'h22;
            end
            if (c == 7) begin
                check_eq("tie_p1_rdata", {24'd0, p1_rdata[1]}, 32'h22);
                check_eq("tie_p0_keep", {24'd0, p0_rdata[1]}, 32'h11);
                p1_req = 1'b0;
            end
        end

        // ---------------- WS=1: both held, 4 alternating accesses ----------------
        do_reset();
        p0_req = 1'b1; p1_req = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            check_eq($sformatf("rr_c%0d", c), st(1), rr_exp[c % 8]);
        end
        p0_req = 1'b0; p1_req = 1'b0;
        tick();
        check_eq("rr_end_idle", st(1), S_IDLE);

        // ---------------- WS=3: reset in 2nd ACCESS cycle ----------------
        do_reset();
        p0_req = 1'b1; p0_addr = 16'h1234; mem_rdata = 8'h99;
        tick();
        check_eq("rstacc_n1", st(2), S_ACC0);
        check_eq("rstacc_addr", {16'd0, mem_addr[2]}, 32'h1234);
        tick();
        check_eq("rstacc_n2", st(2), S_ACC0);
        reset = 1'b1;
        tick();
        check_eq("rstacc_after", st(2), S_IDLE);
        check_eq("rstacc_addr0", {16'd0, mem_addr[2]}, 32'h0);
        reset = 1'b0; p0_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check_eq($sformatf("rstacc_noack%0d", c), st(2), S_IDLE);
        end
        check_eq("rstacc_rdata", {24'd0, p0_rdata[2]}, 32'h00);

        // ---------------- WS=3: addr change and req drop mid-ACCESS ----------------
        do_reset();
        p0_req = 1'b1; p0_addr = 16'h0000; mem_rdata = 8'h77;
        tick();
        check_eq("hold_n1", st(2), S_ACC0);
        p0_addr = 16'h0100;
        p0_req = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            tick();
            check_eq($sformatf("hold_n%0d", c), st(2), S_ACC0);
            check_eq($sformatf("hold_addr_n%0d", c), {16'd0, mem_addr[2]}, 32'h0000);
        end
        tick();
        check_eq("hold_n5_ack", st(2), S_DONE0);
        check_eq("hold_addr_done", {16'd0, mem_addr[2]}, 32'h0000);
        check_eq("hold_rdata", {24'd0, p0_rdata[2]}, 32'h77);
        tick();
        check_eq("hold_idle", st(2), S_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
